spi_cmd_sequencer: RTL
======================

// Module: spi_cmd_sequencer
// PURPOSE
//   Host-side SPI master that sequences command words into the rapcore SPI slave (SCK/CS/COPI/CIPO).
//   Buffers commands in a small FIFO and gates each transfer on the target's BUFFER_DTR flag.
//   Returns the full-duplex CIPO word for each transfer.
//   Used in harness/bench and FPGA bring-up to drive move/config commands without CPU bit-banging.
// PARAMETERS
//   WORD_W      64  bits per transfer (one CS-low frame)
//   CLK_DIV     4   CLK cycles per SCK half-period (>=2)
//   FIFO_DEPTH  4   command FIFO entries (power of 2)
//   CS_GAP      8   CLK cycles CS held high between frames (>=1)
// PORTS
//   CLK         in   1       system clock; all logic on posedge
//   reset       in   1       synchronous, active-high reset
//   cmd_data    in   WORD_W  command word to transmit, MSB first
//   cmd_valid   in   1       cmd_data valid
//   cmd_ready   out  1       FIFO can accept (=!full); push on valid&&ready
//   rsp_data    out  WORD_W  word captured on CIPO during the last frame
//   rsp_valid   out  1       one-cycle pulse: rsp_data updated
//   BUFFER_DTR  in   1       target ready for next command (async, synchronised here)
//   SCK         out  1       SPI clock, mode 0 (idle low)
//   CS          out  1       chip select, active low
//   COPI        out  1       controller-out data
//   CIPO        in   1       controller-in data
//   busy        out  1       high whenever state != IDLE
//   words_sent  out  16      count of completed frames, wraps 16'hFFFF->0
// BEHAVIOUR
//   Reset: CS=1, SCK=0, COPI=0, rsp_data=0, rsp_valid=0, busy=0, words_sent=0, FIFO emptied, cmd_ready=1.
//   Reset mid-frame aborts immediately: next edge CS=1, SCK=0; queued words are dropped; no rsp_valid.
//   BUFFER_DTR passes a 2-flop synchroniser (dtr_s); CIPO is sampled directly.
//   FIFO: push when cmd_valid&&cmd_ready. cmd_ready=0 when full, even if a pop happens that cycle.
//   FIFO: pop only in WAIT_DTR->SETUP. Pointers wrap modulo FIFO_DEPTH.
//   States:
//   IDLE: FIFO non-empty -> WAIT_DTR.
//   WAIT_DTR: dtr_s=1 -> pop head into shift reg, CS=0, COPI=head[WORD_W-1] -> SETUP. dtr_s=0 -> wait.
//   SETUP: CLK_DIV cycles, SCK=0 -> SHIFT_HI.
//   SHIFT_HI: SCK=1 for CLK_DIV cycles; CIPO shifted into rx LSB on the entry cycle.
//   SHIFT_LO: SCK=0 for CLK_DIV cycles; on entry COPI = next bit (MSB-first).
//   Bit loop: bit counter counts WORD_W SHIFT_HI/SHIFT_LO pairs.
//   After bit WORD_W-1's SHIFT_HI -> HOLD (no further COPI change).
//   HOLD: CLK_DIV cycles, SCK=0, CS=0.
//   HOLD exit: CS=1, rsp_data=rx, rsp_valid=1 for one cycle, words_sent+=1 -> GAP.
//   GAP: CS_GAP cycles, CS=1 -> IDLE.
//   Frame timing: CS low for exactly CLK_DIV*(2*WORD_W+2) cycles; exactly WORD_W SCK rising edges.
//   Back-to-back: CS high for exactly CS_GAP+1 cycles between frames when FIFO non-empty and dtr_s=1 (the extra cycle is IDLE).
//   BUFFER_DTR is checked only in WAIT_DTR; a drop mid-frame does not stall or abort the frame.
//   Simultaneous push into an empty FIFO while in IDLE: the entry is visible the next cycle (no bypass).
//   COPI holds its last value while CS=1; it is set to 0 only by reset.
// TESTING
//   1 Reset:
//     Assert reset 3 cycles -> CS=1, SCK=0, busy=0, cmd_ready=1, words_sent=0, rsp_valid=0.
//   2 Single frame (CLK_DIV=4, CIPO looped to COPI):
//     DTR=1; push 64'hA5A5_0000_DEAD_BEEF.
//     -> CS low exactly 520 cycles; 64 SCK rises; COPI bits MSB-first match the word.
//     -> rsp_data=64'hA5A5_0000_DEAD_BEEF; one rsp_valid pulse; words_sent=1.
//   3 DTR gating:
//     DTR=0; push a word -> CS stays 1 for 100 cycles.
//     Raise DTR -> CS falls 3 cycles later (2 sync + 1).
//   4 Full FIFO:
//     DTR=0; offer 5 words -> cmd_ready=0 after 4 accepts; the 5th is held.
//     Raise DTR -> cmd_ready returns 1 the cycle after the pop; all 5 frames are sent in order.
//   5 Reset mid-frame:
//     Assert reset at bit 30 -> next edge CS=1, SCK=0, FIFO empty, no rsp_valid, words_sent=0.
//   6 Back-to-back with wrap (DTR=1):
//     Preload words_sent=16'hFFFE by forcing it; send 3 words.
//     -> CS high exactly CS_GAP+1 cycles between frames.
//     -> words_sent goes FFFF, 0000, 0001.

Source files
------------

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: host-side SPI master (mode 0) that drains a small command
// FIFO into an SPI target. Each transfer is one CS-low frame of WORD_W bits.
// A frame starts only when the target raises BUFFER_DTR. The word clocked in
// on CIPO during the frame is returned on rsp_data with a one-cycle rsp_valid.
module spi_cmd_sequencer #(
    parameter int WORD_W     = 64,
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CS_GAP     = 8
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [WORD_W-1:0] cmd_data,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic [WORD_W-1:0] rsp_data,
    output logic              rsp_valid,
    input  logic              BUFFER_DTR,
    output logic              SCK,
    output logic              CS,
    output logic              COPI,
    input  logic              CIPO,
    output logic              busy,
    output logic [15:0]       words_sent
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = PTR_W + 1;
    localparam int BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int CNT_W  = 16;
    // CS stays high through GAP, then one IDLE cycle and one WAIT_DTR cycle.
    // GAP is shortened by one so that a back-to-back gap is CS_GAP+1 cycles.
    localparam int GAP_LEN = (CS_GAP > 1) ? CS_GAP - 1 : 1;

    localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [FCNT_W-1:0] FULL_COUNT = FCNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_LEN - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DTR,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD,
        GAP
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FCNT_W-1:0] fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    assign fifo_full  = (fifo_count == FULL_COUNT);
    assign fifo_empty = (fifo_count == '0);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && cmd_ready;

    // FIFO storage: written on an accepted push, no reset needed
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_data;
        end
    end

    // FIFO pointers and occupancy; reset empties the FIFO
    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
                2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // BUFFER_DTR synchroniser
    // ------------------------------------------------------------------
    logic dtr_meta;
    logic dtr_s;

    // Two-flop synchroniser for the asynchronous target-ready flag
    always_ff @(posedge CLK) begin
        if (reset) begin
            dtr_meta <= 1'b0;
            dtr_s    <= 1'b0;
        end else begin
            dtr_meta <= BUFFER_DTR;
            dtr_s    <= dtr_meta;
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_next;
    logic              cs_q;
    logic              cs_next;
    logic              sck_q;
    logic              sck_next;
    logic              copi_q;
    logic              copi_next;
    logic              load_tx;
    logic              shift_tx;
    logic              capture_rx;
    logic              frame_done;
    logic [WORD_W-1:0] tx_reg;
    logic [WORD_W-1:0] rx_reg;

    // State and pin registers; reset aborts any frame in progress
    always_ff @(posedge CLK) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            copi_q  <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_cnt <= bit_next;
            cs_q    <= cs_next;
            sck_q   <= sck_next;
            copi_q  <= copi_next;
        end
    end

    // Next-state logic: each phase lasts CLK_DIV cycles, pins change on phase entry
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_cnt;
        cs_next    = cs_q;
        sck_next   = sck_q;
        copi_next  = copi_q;
        pop        = 1'b0;
        load_tx    = 1'b0;
        shift_tx   = 1'b0;
        capture_rx = 1'b0;
        frame_done = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!fifo_empty) begin
                    state_next = WAIT_DTR;
                end
            end

            WAIT_DTR: begin
                if (dtr_s && !fifo_empty) begin
                    pop        = 1'b1;
                    load_tx    = 1'b1;
                    cs_next    = 1'b0;
                    sck_next   = 1'b0;
                    copi_next  = fifo_mem[rd_ptr][WORD_W-1];
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = SETUP;
                end
            end

            SETUP: begin
                if (cnt == DIV_LAST) begin
                    cnt_next   = '0;
                    sck_next   = 1'b1;
                    state_next = SHIFT_HI;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            SHIFT_HI: begin
                capture_rx = (cnt == '0);
                if (cnt == DIV_LAST) begin
                    cnt_next   = '0;
                    sck_next   = 1'b0;
                    state_next = SHIFT_LO;
                    if (bit_cnt != BIT_LAST) begin
                        shift_tx  = 1'b1;
                        copi_next = tx_reg[WORD_W-2];
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            SHIFT_LO: begin
                if (cnt == DIV_LAST) begin
                    cnt_next = '0;
                    if (bit_cnt == BIT_LAST) begin
                        state_next = HOLD;
                    end else begin
                        bit_next   = bit_cnt + BIT_W'(1);
                        sck_next   = 1'b1;
                        state_next = SHIFT_HI;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            HOLD: begin
                if (cnt == DIV_LAST) begin
                    cnt_next   = '0;
                    cs_next    = 1'b1;
                    frame_done = 1'b1;
                    state_next = GAP;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Transmit shifter: the outgoing bit always sits in the MSB
    always_ff @(posedge CLK) begin
        if (reset) begin
            tx_reg <= '0;
        end else if (load_tx) begin
            tx_reg <= fifo_mem[rd_ptr];
        end else if (shift_tx) begin
            tx_reg <= {tx_reg[WORD_W-2:0], 1'b0};
        end
    end

    // Receive shifter: CIPO enters at the LSB once per SCK high phase
    always_ff @(posedge CLK) begin
        if (reset) begin
            rx_reg <= '0;
        end else if (capture_rx) begin
            rx_reg <= {rx_reg[WORD_W-2:0], CIPO};
        end
    end

    // Response publication and frame counter, updated when a frame completes
    always_ff @(posedge CLK) begin
        if (reset) begin
            rsp_data   <= '0;
            rsp_valid  <= 1'b0;
            words_sent <= '0;
        end else begin
            rsp_valid <= frame_done;
            if (frame_done) begin
                rsp_data   <= rx_reg;
                words_sent <= words_sent + 16'd1;
            end
        end
    end

    assign busy = (state != IDLE);
    assign CS   = cs_q;
    assign SCK  = sck_q;
    assign COPI = copi_q;

endmodule
